// File: rtl/clken_gen.sv
// Programmable multi-channel clock-enable generator: per-channel divide,
// phase and high time, with a settle window before locked asserts.
module clken_gen #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_div,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_phase,
  input  logic [NUM_CH*CNT_W-1:0]   cfg_high,
  input  logic [NUM_CH-1:0]         cfg_en,
  output logic [NUM_CH-1:0]         outclk,
  output logic [NUM_CH-1:0]         outen,
  output logic                      locked,
  output logic                      cfg_err
);

  localparam int unsigned CW = CNT_W + 1;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_e;

  state_e                     state_q, state_d;
  logic                       rst_sync_q;
  logic                       cfg_ready_q, cfg_ready_d;
  logic                       locked_q, locked_d;
  logic                       cfg_err_q, cfg_err_d;
  logic [SW-1:0]              settle_q, settle_d;
  logic [NUM_CH-1:0][CW-1:0]  div_q, div_d;
  logic [NUM_CH-1:0][CW-1:0]  phase_q, phase_d;
  logic [NUM_CH-1:0][CW-1:0]  high_q, high_d;
  logic [NUM_CH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic [NUM_CH-1:0]          outclk_q, outclk_d;
  logic [NUM_CH-1:0]          outen_q, outen_d;
  logic                       accept;
  logic                       clamp_any;

  // Deassertion is registered once before any configuration can be accepted.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      settle_q    <= '0;
      div_q       <= '0;
      phase_q     <= '0;
      high_q      <= '0;
      cnt_q       <= '0;
      en_q        <= '0;
      outclk_q    <= '0;
      outen_q     <= '0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      locked_q    <= locked_d;
      cfg_err_q   <= cfg_err_d;
      settle_q    <= settle_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      high_q      <= high_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      outclk_q    <= outclk_d;
      outen_q     <= outen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    settle_d  = settle_q;
    div_d     = div_q;
    phase_d   = phase_q;
    high_d    = high_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    outclk_d  = '0;
    outen_d   = '0;
    clamp_any = 1'b0;
    accept    = cfg_valid & cfg_ready_q & rst_sync_q;

    case (state_q)
      IDLE: ;
      LOAD: begin
        // Raw fields were captured on accept; clamp them in place here.
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (phase_q[i] >= div_q[i]) begin
            phase_d[i] = '0;
            if (en_q[i]) clamp_any = 1'b1;
          end
          if (high_q[i] > div_q[i]) begin
            high_d[i] = div_q[i];
            if (en_q[i]) clamp_any = 1'b1;
          end
        end
        cfg_err_d = clamp_any;
        settle_d  = SW'(LOCK_CYC - 1);
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = RUN;
          for (int i = 0; i < int'(NUM_CH); i++)
            cnt_d[i] = (phase_q[i] != '0) ? div_q[i] - phase_q[i] : '0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          outclk_d[i] = (cnt_q[i] < high_q[i]) & en_q[i];
          outen_d[i]  = (cnt_q[i] == '0) & (high_q[i] != '0) & en_q[i];
          cnt_d[i]    = (cnt_q[i] == div_q[i] - CW'(1)) ? '0 : cnt_q[i] + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept overrides everything: outputs drop on this very edge.
    if (accept) begin
      state_d  = LOAD;
      outclk_d = '0;
      outen_d  = '0;
      cnt_d    = '0;
      en_d     = cfg_en;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        div_d[i]   = CW'(cfg_div[i*CNT_W +: CNT_W]) + CW'(1);
        phase_d[i] = CW'(cfg_phase[i*CNT_W +: CNT_W]);
        high_d[i]  = CW'(cfg_high[i*CNT_W +: CNT_W]);
      end
    end

    locked_d    = (state_d == RUN);
    cfg_ready_d = (state_d == IDLE) | (state_d == RUN);
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;
  assign cfg_err   = cfg_err_q;
  assign outclk    = outclk_q;
  assign outen     = outen_q;

endmodule

// File: tb/tb_clken_gen.sv
// Scoreboard bench for clken_gen: a cycle model pushes the expected outputs
// for every edge, which are popped and compared one cycle later.
module tb_clken_gen;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned LC  = 4;

  logic                 refclk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [NCH*CW-1:0]    cfg_div = '0;
  logic [NCH*CW-1:0]    cfg_phase = '0;
  logic [NCH*CW-1:0]    cfg_high = '0;
  logic [NCH-1:0]       cfg_en = '0;
  logic [NCH-1:0]       outclk;
  logic [NCH-1:0]       outen;
  logic                 locked;
  logic                 cfg_err;

  clken_gen #(.NUM_CH(NCH), .CNT_W(CW), .LOCK_CYC(LC)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_high(cfg_high), .cfg_en(cfg_en),
    .outclk(outclk), .outen(outen), .locked(locked), .cfg_err(cfg_err)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  // Reference model state
  int m_t;
  int m_rel;
  bit m_ready;
  bit m_err;
  int m_d[NCH];
  int m_p[NCH];
  int m_h[NCH];
  bit m_en[NCH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = -1; m_rel = 0; m_ready = 1'b1; m_err = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      m_d[i] = 1; m_p[i] = 0; m_h[i] = 0; m_en[i] = 1'b0;
    end
  endtask

  // Predict outputs after the coming edge from the inputs currently driven.
  task automatic model_edge();
    bit acc;
    logic [1:0] ec, ee;
    int n, m;
    acc = cfg_valid && m_ready && (m_rel >= 1);
    if (m_rel < 10) m_rel++;
    if (acc) begin
      m_t = 0;
      for (int i = 0; i < int'(NCH); i++) begin
        m_d[i]  = int'(cfg_div[i*CW +: CW]) + 1;
        m_p[i]  = int'(cfg_phase[i*CW +: CW]);
        m_h[i]  = int'(cfg_high[i*CW +: CW]);
        m_en[i] = cfg_en[i];
      end
    end else if (m_t >= 0) begin
      m_t++;
    end
    if (m_t == 1) begin
      m_err = 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        if (m_p[i] >= m_d[i]) begin m_p[i] = 0; if (m_en[i]) m_err = 1'b1; end
        if (m_h[i] > m_d[i])  begin m_h[i] = m_d[i]; if (m_en[i]) m_err = 1'b1; end
      end
    end
    m_ready = (m_t < 0) || (m_t >= int'(LC) + 1);
    ec = '0; ee = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (m_t >= int'(LC) + 2 && m_en[i]) begin
        n = m_t - (int'(LC) + 2) - m_p[i];
        m = ((n % m_d[i]) + m_d[i]) % m_d[i];
        ec[i] = (m < m_h[i]);
        ee[i] = (m == 0) && (m_h[i] != 0);
      end
    end
    exp_q.push_back({ec, ee, (m_t >= int'(LC) + 1), m_ready, m_err});
  endtask

  task automatic step(input string tag);
    logic [6:0] e;
    model_edge();
    @(posedge refclk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, " empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s t=%0d", tag, m_t),
               32'({outclk, outen, locked, cfg_ready, cfg_err}), 32'(e));
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic set_cfg(input logic [7:0] d0, input logic [7:0] p0, input logic [7:0] h0,
                         input logic [7:0] d1, input logic [7:0] p1, input logic [7:0] h1,
                         input logic [1:0] en);
    cfg_div   = {d1, d0};
    cfg_phase = {p1, p0};
    cfg_high  = {h1, h0};
    cfg_en    = en;
  endtask

  task automatic offer(input string tag);
    cfg_valid = 1'b1;
    step(tag);
    cfg_valid = 1'b0;
  endtask

  // Pulse reset between edges and confirm outputs clear with no clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq({tag, " async"}, 32'({outclk, outen, locked, cfg_ready, cfg_err}), 32'(7'b0000010));
    @(posedge refclk);
    #1;
    check_eq({tag, " held"}, 32'({outclk, outen, locked, cfg_ready, cfg_err}), 32'(7'b0000010));
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_eq("reset", 32'({outclk, outen, locked, cfg_ready, cfg_err}), 32'(7'b0000010));
    @(posedge refclk);
    @(posedge refclk);
    #1 rst_n = 1'b1;

    // Basic two-channel pattern; valid from the first edge after release.
    set_cfg(8'd3, 8'd0, 8'd2, 8'd3, 8'd2, 8'd2, 2'b11);
    cfg_valid = 1'b1;
    step("sync");
    step("sync");
    cfg_valid = 1'b0;
    run("scn1", 22);

    // Reconfigure mid-RUN: D=1,H=1 and D=1,H=0.
    set_cfg(8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 2'b11);
    offer("scn4");
    run("scn2", 14);

    // Clamped fields on an enabled channel.
    set_cfg(8'd4, 8'd7, 8'd9, 8'd2, 8'd1, 8'd1, 2'b11);
    offer("scn3");
    run("scn3", 20);

    // Clamped fields only on a disabled channel.
    set_cfg(8'd5, 8'd2, 8'd3, 8'd1, 8'd5, 8'd9, 2'b01);
    offer("dis");
    run("dis", 18);

    // Valid held through LOAD/SETTLE: re-accepts only when ready.
    set_cfg(8'd3, 8'd1, 8'd3, 8'd2, 8'd0, 8'd1, 2'b11);
    cfg_valid = 1'b1;
    run("scn6", 16);
    cfg_valid = 1'b0;
    run("scn6", 10);

    // Full-width divide exercising the extra counter bit.
    set_cfg(8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd1, 2'b11);
    offer("wide");
    run("wide", 2 * 256 + 10);

    // Randomised small configurations.
    for (int r = 0; r < 8; r++) begin
      set_cfg(8'($urandom_range(0, 6)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)),
              8'($urandom_range(0, 6)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)),
              2'($urandom_range(0, 3)));
      offer("rnd");
      run("rnd", 26);
    end

    // Reset mid-SETTLE.
    set_cfg(8'd3, 8'd0, 8'd2, 8'd3, 8'd2, 8'd2, 2'b11);
    offer("pre");
    run("pre", 3);
    async_reset("rst_settle");

    // Reset mid-RUN.
    cfg_valid = 1'b1;
    step("post");
    step("post");
    cfg_valid = 1'b0;
    run("run2", 12);
    async_reset("rst_run");
    run("idle", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
